// File: rtl/tcb_uart_rx_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : tcb_uart_rx_fifo                                              |
// | Description : UART receive buffer. Takes a no-ready deserializer stream,    |
// |               presents a valid/ready stream, and reports level/irq/overflow.|
// | Revision    : 1.0                                                           |
// +-----------------------------------------------------------------------------+
module tcb_uart_rx_fifo #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          sti_vld,
    input  logic [DW-1:0] sti_dat,
    output logic          sto_vld,
    output logic [DW-1:0] sto_dat,
    input  logic          sto_rdy,
    output logic [AW:0]   sts_cnt,
    output logic          sts_ful,
    output logic          sts_emp,
    output logic          sts_ovf,
    input  logic          ovf_clr,
    input  logic [AW:0]   cfg_lvl,
    output logic          irq
);

    logic [DW-1:0] r_mem [0:(1<<AW)-1];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic          r_ovf;

    logic          w_full;
    logic          w_empty;
    logic          w_rd_xfer;
    logic          w_wr_en;
    logic          w_ovf_set;

    // One extra pointer bit distinguishes full from empty when the indices match.
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    assign w_rd_xfer = ~w_empty & sto_rdy & ~clr;
    // A read in the same cycle frees the slot the write lands in.
    assign w_wr_en   = sti_vld & ~clr & (~w_full | w_rd_xfer);
    assign w_ovf_set = sti_vld & ~clr & w_full & ~w_rd_xfer;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (clr) begin
            r_rd_ptr <= r_wr_ptr;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_xfer) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[AW-1:0]] <= sti_dat;
        end
    end

    // Set beats clear when both happen in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_ovf_set) begin
            r_ovf <= 1'b1;
        end else if (ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    assign sts_cnt = r_wr_ptr - r_rd_ptr;
    assign sts_ful = w_full;
    assign sts_emp = w_empty;
    assign sts_ovf = r_ovf;
    assign sto_vld = ~w_empty;
    assign sto_dat = r_mem[r_rd_ptr[AW-1:0]];
    assign irq     = (sts_cnt >= cfg_lvl);

endmodule
`default_nettype wire

// File: tb/tb_tcb_uart_rx_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : tb_tcb_uart_rx_fifo                                           |
// | Description : Self-checking bench for tcb_uart_rx_fifo against a queue model|
// | Revision    : 1.0                                                           |
// +-----------------------------------------------------------------------------+
module tb_tcb_uart_rx_fifo;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clr = 1'b0;
    logic          sti_vld = 1'b0;
    logic [DW-1:0] sti_dat = '0;
    logic          sto_vld;
    logic [DW-1:0] sto_dat;
    logic          sto_rdy = 1'b0;
    logic [AW:0]   sts_cnt;
    logic          sts_ful;
    logic          sts_emp;
    logic          sts_ovf;
    logic          ovf_clr = 1'b0;
    logic [AW:0]   cfg_lvl = 5'd3;
    logic          irq;

    int nvec = 0;
    int nerr = 0;

    logic [DW-1:0] q[$];
    bit            m_ovf = 1'b0;

    always #5 clk = ~clk;

    tcb_uart_rx_fifo #(.DW(DW), .AW(AW)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .sti_vld (sti_vld),
        .sti_dat (sti_dat),
        .sto_vld (sto_vld),
        .sto_dat (sto_dat),
        .sto_rdy (sto_rdy),
        .sts_cnt (sts_cnt),
        .sts_ful (sts_ful),
        .sts_emp (sts_emp),
        .sts_ovf (sts_ovf),
        .ovf_clr (ovf_clr),
        .cfg_lvl (cfg_lvl),
        .irq     (irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        int n;
        n = q.size();
        check("sts_cnt", 32'(sts_cnt), 32'(n));
        check("sts_emp", 32'(sts_emp), 32'(n == 0));
        check("sts_ful", 32'(sts_ful), 32'(n == DEPTH));
        check("sto_vld", 32'(sto_vld), 32'(n != 0));
        check("sts_ovf", 32'(sts_ovf), 32'(m_ovf));
        check("irq",     32'(irq),     32'(n >= int'(cfg_lvl)));
        if (n != 0) check("sto_dat", 32'(sto_dat), 32'(q[0]));
    endtask

    // Check current outputs, apply one cycle of inputs, then advance the model.
    task automatic step(input bit v, input logic [DW-1:0] d, input bit r,
                        input bit c, input bit oc, input bit rs);
        bit full, rd, ovf_set;
        @(negedge clk);
        check_outputs();
        sti_vld = v; sti_dat = d; sto_rdy = r; clr = c; ovf_clr = oc; rst = rs;
        @(posedge clk);
        full    = (q.size() == DEPTH);
        rd      = (q.size() != 0) && r && !c;
        ovf_set = 1'b0;
        if (rs) begin
            q.delete();
            m_ovf = 1'b0;
        end else begin
            if (c) begin
                q.delete();
            end else begin
                if (rd) void'(q.pop_front());
                if (v) begin
                    if (!full || rd) q.push_back(d);
                    else ovf_set = 1'b1;
                end
            end
            if (ovf_set) m_ovf = 1'b1;
            else if (oc) m_ovf = 1'b0;
        end
    endtask

    task automatic idle(input bit r, input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, r, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        repeat (2) @(posedge clk);

        // Basic flow
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hA3, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1'b0, 1);
        idle(1'b1, 4);

        // Fill, overflow, overflow-vs-clear, clear, concurrent read/write when full
        cfg_lvl = 5'd16;
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1'b0, 1);
        step(1'b1, 8'hEF, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(1'b0, 1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1'b0, 1);
        idle(1'b1, DEPTH + 1);

        // Overflow then drain; flag persists until cleared
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1'b1, DEPTH + 1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);

        // Wrap-around stream with random gaps
        cfg_lvl = 5'd2;
        for (int i = 0; i < 100; i++) begin
            step(1'b1, 8'($urandom), 1'b1, 1'b0, 1'b0, 1'b0);
            idle(1'b1, int'($urandom_range(0, 2)));
        end
        idle(1'b1, 2);

        // clr and rst mid-operation
        cfg_lvl = 5'd3;
        for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1'b0, 1);
        step(1'b1, 8'h99, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(1'b0, 1);
        for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1'b1, 2);

        // Random mix of every control
        for (int i = 0; i < 600; i++) begin
            if ((i % 50) == 0) cfg_lvl = 5'($urandom_range(0, DEPTH + 2));
            step(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 60) == 0), ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 200) == 0));
        end
        idle(1'b1, DEPTH + 2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
